instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Parametrised program sequencer and response tracer for the tiny-CPU `top` core. It replaces hand-driven `instr` stimulus in the bench and in on-silicon self-test. It holds a small program memory, feeds one instruction per cycle into the core and follows taken conditional jumps reported on `cjump`. It also timestamps every change on the core's `io_out` into a trace FIFO for readout.

## Interface
Parameters:
- INSTR_W, 6, instruction width (matches core `instr`)
- IO_W, 5, core output width (matches core `io_out`)
- ADDR_W, 4, program address width; DEPTH = 2**ADDR_W; requires ADDR_W <= INSTR_W
- TS_W, 16, timestamp/cycle-counter width
- TRACE_DEPTH, 8, trace FIFO entries (power of two, >= 2)
- MAX_CYCLES, 1000, run watchdog limit (< 2**TS_W)
- NOP_INSTR, 0, instruction driven when not running

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  program-write strobe
- ld_addr  in  ADDR_W  program-write address
- ld_data  in  INSTR_W  program-write data
- last_addr  in  ADDR_W  address of final instruction; sampled at start
- start  in  1  begin run from address 0
- halt  in  1  abort run
- instr  out  INSTR_W  instruction to core
- cjump  in  1  core: current instruction is a taken jump
- io_out  in  IO_W  core outputs
- trace_valid  out  1  FIFO non-empty
- trace_ready  in  1  consumer pop
- trace_data  out  TS_W+IO_W  {timestamp, io_out}, head entry
- busy  out  1  in RUN
- done  out  1  sticky: run finished
- timeout  out  1  sticky: run ended by watchdog
- overflow  out  1  sticky: trace entry dropped

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values:
  - pc=0, cycle=0, FIFO empty.
  - busy/done/timeout/overflow=0, trace_valid=0.
  - instr=NOP_INSTR.
  - Program memory is not reset; contents persist across rst.
- Load: in IDLE or DONE, ld_valid writes mem[ld_addr]=ld_data at the edge. It is ignored in RUN.
- IDLE/DONE with start=1 and halt=0:
  - → RUN.
  - pc=0, cycle=0, last_addr latched.
  - done, timeout and overflow cleared.
  - FIFO flushed.
- RUN, instr=mem[pc] combinationally; each cycle:
  - Trace: on the first RUN cycle, push {cycle, io_out} unconditionally. Afterwards, push when io_out differs from the previous RUN cycle's sample. The previous sample updates every cycle, including when a push is dropped.
  - Next pc:
    - cjump=1 → mem[pc][ADDR_W-1:0] (jump target in low bits of the jump instruction).
    - Otherwise pc+1, wrapping mod DEPTH.
  - End: pc==last_addr and cjump=0 → DONE, done=1.
  - Watchdog: cycle==MAX_CYCLES-1 → DONE, done=1, timeout=1.
  - halt=1 → DONE, done=1; halt has priority over every other transition.
  - cycle increments per RUN cycle.
- DONE: instr=NOP_INSTR. FIFO stays readable. start re-runs the program.
- start in RUN is ignored. halt in IDLE/DONE is ignored.
- Trace FIFO behaviour:
  - First-word-fall-through: trace_data is the head whenever trace_valid=1; pop when trace_valid && trace_ready.
  - Push when full without a simultaneous pop: entry dropped, overflow=1.
  - Full with simultaneous pop and push: both occur, no overflow.
  - Empty: trace_ready is ignored.
- Readout is allowed in any state. A start flush discards unread entries.

## Timing
- instr is combinational from pc. The core sees mem[0] in the first cycle after the start edge.
- cjump is sampled in the same cycle as the instruction it qualifies. The jump target is presented in the next cycle (zero-bubble redirect).
- Trace latency: a push at edge t gives trace_valid=1 after edge t. Pop takes effect at the edge.
- busy=1 exactly in RUN. done, timeout and overflow are registered, set at the terminating edge, and cleared only by start or rst.
- rst mid-run: outputs return to reset values asynchronously, the FIFO is emptied and the program is kept.
- Timestamps wrap mod 2**TS_W. The watchdog guarantees no wrap within one run.

## Test plan
- Linear program: load mem[0..3]=1,2,3,4, last_addr=3, start, io_out constant 5'h0A.
  - Required: instr sequence 1,2,3,4, then NOP.
  - done=1 four cycles after start, busy=0.
  - One trace entry {0,0x0A}.
- Jump redirect: mem[2]=6'h05, cjump=1 while instr==6'h05, last_addr=7.
  - Required: pc sequence 0,1,2,5,6,7 → DONE.
- Watchdog: mem[3]=6'h03 with cjump=1 on it (self-loop), MAX_CYCLES=20.
  - Required: DONE after 20 RUN cycles with timeout=1.
- Trace overflow: TRACE_DEPTH=8, io_out toggles every cycle for 12 cycles, trace_ready=0.
  - Required: 8 entries with timestamps 0..7, overflow=1.
  - Simultaneous pop and push at full: no overflow.
- Halt and reset: halt on cycle 2 gives done=1, timeout=0.
  - Restart with rst pulsed mid-run: all outputs reset immediately.
  - Following start replays the unchanged program.
- Load lockout: ld_valid during RUN to addr 1 leaves mem[1] unchanged on the next run.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer and io_out tracer for the tiny-CPU core.
// It feeds one instruction per cycle from a small program memory and follows taken jumps.
// Every change on io_out is timestamped into a first-word-fall-through trace FIFO.
module instr_sequencer #(
   parameter int unsigned        INSTR_W     = 6,
   parameter int unsigned        IO_W        = 5,
   parameter int unsigned        ADDR_W      = 4,
   parameter int unsigned        TS_W        = 16,
   parameter int unsigned        TRACE_DEPTH = 8,
   parameter int unsigned        MAX_CYCLES  = 1000,
   parameter logic [INSTR_W-1:0] NOP_INSTR   = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld_valid,
   input  logic [ADDR_W-1:0]    ld_addr,
   input  logic [INSTR_W-1:0]   ld_data,
   input  logic [ADDR_W-1:0]    last_addr,
   input  logic                 start,
   input  logic                 halt,
   output logic [INSTR_W-1:0]   instr,
   input  logic                 cjump,
   input  logic [IO_W-1:0]      io_out,
   output logic                 trace_valid,
   input  logic                 trace_ready,
   output logic [TS_W+IO_W-1:0] trace_data,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic                 overflow
);

   localparam int unsigned DEPTH   = 2 ** ADDR_W;
   localparam int unsigned FAW     = $clog2(TRACE_DEPTH);
   localparam int unsigned PW      = FAW + 1;
   localparam int unsigned ENTRY_W = TS_W + IO_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   last_q;
   logic [TS_W-1:0]     cycle;
   logic [IO_W-1:0]     prev_io;
   logic                first;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;

   logic [INSTR_W-1:0]  mem  [DEPTH];
   logic [ENTRY_W-1:0]  fifo [TRACE_DEPTH];

   logic                run;
   logic                launch;
   logic [INSTR_W-1:0]  cur;
   logic                fifo_full;
   logic                pop;
   logic                push;
   logic                push_ok;

   // Decode of current state, FIFO status and the trace push/pop handshake
   always_comb begin
      run         = (state == S_RUN);
      launch      = !run && start && !halt;
      cur         = mem[pc];
      instr       = run ? cur : NOP_INSTR;
      busy        = run;
      trace_valid = (wr_ptr != rd_ptr);
      fifo_full   = ((wr_ptr - rd_ptr) == PW'(TRACE_DEPTH));
      pop         = trace_valid && trace_ready;
      push        = run && (first || (io_out != prev_io));
      push_ok     = push && (!fifo_full || pop);
      trace_data  = fifo[rd_ptr[FAW-1:0]];
   end

   // Program memory: writable outside RUN, deliberately not reset
   always_ff @(posedge clk) begin
      if (ld_valid && !run) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Trace storage; a push at full with a pop reuses the slot being popped
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo[wr_ptr[FAW-1:0]] <= {cycle, io_out};
      end
   end

   // Run control FSM, pc/cycle tracking, FIFO pointers and sticky status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= '0;
         last_q   <= '0;
         cycle    <= '0;
         prev_io  <= '0;
         first    <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         done     <= 1'b0;
         timeout  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (launch) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (launch) begin
                  state    <= S_RUN;
                  pc       <= '0;
                  cycle    <= '0;
                  last_q   <= last_addr;
                  first    <= 1'b1;
                  done     <= 1'b0;
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            S_RUN: begin
               first   <= 1'b0;
               prev_io <= io_out;
               cycle   <= cycle + TS_W'(1);
               pc      <= cjump ? cur[ADDR_W-1:0] : pc + ADDR_W'(1);
               if (halt) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else if (cycle == TS_W'(MAX_CYCLES - 1)) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end else if ((pc == last_q) && !cjump) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table for straight-line and jump runs,
// hand sequences for watchdog, trace overflow, halt, mid-run reset and load lockout.
module tb_instr_sequencer;

   localparam int unsigned INSTR_W = 6;
   localparam int unsigned IO_W    = 5;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned TS_W    = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 ld_valid = 1'b0;
   logic [ADDR_W-1:0]    ld_addr = '0;
   logic [INSTR_W-1:0]   ld_data = '0;
   logic [ADDR_W-1:0]    last_addr = '0;
   logic                 start = 1'b0;
   logic                 halt = 1'b0;
   logic [INSTR_W-1:0]   instr;
   logic                 cjump;
   logic [IO_W-1:0]      io_out = '0;
   logic                 trace_valid;
   logic                 trace_ready = 1'b0;
   logic [TS_W+IO_W-1:0] trace_data;
   logic                 busy;
   logic                 done;
   logic                 timeout;
   logic                 overflow;

   logic                 cj_mode = 1'b0;
   logic [INSTR_W-1:0]   cj_instr = '0;

   int nchk  = 0;
   int nfail = 0;

   // Model of the core: reports a taken jump whenever the chosen jump opcode is presented
   assign cjump = cj_mode && (instr == cj_instr);

   always #5 clk = ~clk;

   instr_sequencer #(
      .INSTR_W(INSTR_W), .IO_W(IO_W), .ADDR_W(ADDR_W), .TS_W(TS_W),
      .TRACE_DEPTH(8), .MAX_CYCLES(20), .NOP_INSTR(6'h00)
   ) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .last_addr(last_addr), .start(start), .halt(halt),
      .instr(instr), .cjump(cjump), .io_out(io_out),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
      .busy(busy), .done(done), .timeout(timeout), .overflow(overflow)
   );

   typedef struct {
      logic               start;
      logic [ADDR_W-1:0]  last;
      logic [IO_W-1:0]    io;
      logic [INSTR_W-1:0] exp_instr;
      logic               exp_busy;
      logic               exp_done;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      step();
      ld_valid = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         start     = vecs[i].start;
         last_addr = vecs[i].last;
         io_out    = vecs[i].io;
         chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
         chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].exp_done));
         step();
      end
      start = 1'b0;
   endtask

   task automatic pop_one();
      trace_ready = 1'b1;
      step();
      trace_ready = 1'b0;
   endtask

   // Global time limit so the run can never hang
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "time limit");
   end

   initial begin
      // Straight-line program, io constant
      vecs[0]  = '{1'b1, 4'd3, 5'h0A, 6'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'd3, 5'h0A, 6'h01, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 4'd3, 5'h0A, 6'h02, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 4'd3, 5'h0A, 6'h03, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 4'd3, 5'h0A, 6'h04, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 4'd3, 5'h0A, 6'h00, 1'b0, 1'b1};
      // Jump at address 2 to address 5, end at 7
      vecs[6]  = '{1'b1, 4'd7, 5'h00, 6'h00, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 4'd7, 5'h00, 6'h20, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 4'd7, 5'h00, 6'h21, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 4'd7, 5'h00, 6'h05, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 4'd7, 5'h00, 6'h25, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 4'd7, 5'h00, 6'h26, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 4'd7, 5'h00, 6'h27, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 4'd7, 5'h00, 6'h00, 1'b0, 1'b1};

      // Reset state
      #3;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_trace_valid", 32'(trace_valid), 0);
      chk("rst_instr", 32'(instr), 0);
      #4;
      rst = 1'b0;
      step();

      // Straight-line run
      for (int i = 0; i < 4; i++) load(ADDR_W'(i), INSTR_W'(i + 1));
      run_vecs(0, 5);
      chk("lin_trace_valid", 32'(trace_valid), 1);
      chk("lin_trace_data", 32'(trace_data), {11'd0, 16'd0, 5'h0A});
      pop_one();
      chk("lin_trace_empty", 32'(trace_valid), 0);

      // Jump redirect
      for (int i = 0; i < 16; i++) load(ADDR_W'(i), 6'h20 | INSTR_W'(i));
      load(4'd2, 6'h05);
      cj_mode  = 1'b1;
      cj_instr = 6'h05;
      run_vecs(6, 13);
      cj_mode = 1'b0;

      // Watchdog: self-loop at address 3
      load(4'd2, 6'h22);
      load(4'd3, 6'h03);
      cj_mode   = 1'b1;
      cj_instr  = 6'h03;
      last_addr = 4'd15;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 19; k++) step();
      chk("wd_busy_before", 32'(busy), 1);
      chk("wd_instr_loop", 32'(instr), 32'h03);
      step();
      chk("wd_done", 32'(done), 1);
      chk("wd_timeout", 32'(timeout), 1);
      chk("wd_busy_after", 32'(busy), 0);
      cj_mode = 1'b0;
      load(4'd3, 6'h23);

      // Trace overflow: 12 toggles, no reads
      last_addr = 4'd15;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ovf_cleared_on_start", 32'(timeout), 0);
      for (int k = 0; k < 16; k++) begin
         io_out = (k >= 11 || (k % 2) == 1) ? 5'h15 : 5'h0A;
         step();
      end
      chk("ovf_done", 32'(done), 1);
      chk("ovf_timeout", 32'(timeout), 0);
      chk("ovf_overflow", 32'(overflow), 1);
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("ovf_valid%0d", j), 32'(trace_valid), 1);
         chk($sformatf("ovf_data%0d", j), 32'(trace_data),
             {11'd0, 16'(j), ((j % 2) == 1) ? 5'h15 : 5'h0A});
         pop_one();
      end
      chk("ovf_empty", 32'(trace_valid), 0);

      // Simultaneous pop and push at full
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         io_out      = (k <= 8 && (k % 2) == 1) ? 5'h15 : 5'h0A;
         trace_ready = (k == 8);
         step();
      end
      trace_ready = 1'b0;
      chk("full_pp_done", 32'(done), 1);
      chk("full_pp_overflow", 32'(overflow), 0);
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("full_pp_data%0d", j), 32'(trace_data),
             {11'd0, 16'(j + 1), ((j % 2) == 0) ? 5'h15 : 5'h0A});
         pop_one();
      end
      chk("full_pp_empty", 32'(trace_valid), 0);

      // Halt on cycle 2
      last_addr = 4'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("halt_instr_c2", 32'(instr), 32'h22);
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("halt_done", 32'(done), 1);
      chk("halt_timeout", 32'(timeout), 0);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_instr_nop", 32'(instr), 0);

      // Reset mid-run
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("mid_busy", 32'(busy), 1);
      chk("mid_trace_valid", 32'(trace_valid), 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_trace_valid", 32'(trace_valid), 0);
      chk("mid_rst_instr", 32'(instr), 0);
      #1 rst = 1'b0;
      step();

      // Replay after reset with a blocked load during RUN
      last_addr = 4'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("replay_instr%0d", k), 32'(instr), 32'(6'h20 | INSTR_W'(k)));
         ld_valid = (k == 1);
         ld_addr  = 4'd1;
         ld_data  = 6'h3F;
         step();
      end
      ld_valid = 1'b0;
      chk("replay_done", 32'(done), 1);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("lockout_mem1", 32'(instr), 32'h21);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
